// File: rtl/tlc_driver_sequencer.sv
// rtl/tlc_driver_sequencer.sv - SCLK/GCLK/LAT/SIN sequencer for daisy-chained TLC5957-class LED drivers
//
// Purpose: runs the FCWRTEN/WRTFC configuration sequence, then streams grayscale
// words (WRTGS/LATGS) while GCLK runs one PWM segment per mux row. The framebuffer
// is paced by driver_ready, the column mux by column_ready.
// Optional feature macro: LINERESET_EN -- the last segment of every slice ends
// with LINERESET (LAT on the last 7 SCLKs) instead of LATGS.
//
// Ports:
//   clk, nrst                 clock, synchronous active-low reset
//   clk_enable                driver-rate strobe, all state advances only when high
//   framebuffer_dat           current bit for each SIN lane
//   serialized_conf           function-control word, MSB shifted first
//   new_configuration_ready   request (re)configuration, aborts streaming
//   position_sync             start of the next slice
//   drv_sclk, drv_gclk        gated copies of clk_enable (combinational)
//   drv_lat, drv_sin          registered on clk_enable, one slot behind SCLK
//   column_ready              one-clk pulse at the end of each segment
//   driver_ready              framebuffer may present the next bit
//   sync_overrun              one-clk pulse when position_sync hits an active slice
module tlc_driver_sequencer #(
  parameter int NB_LANES  = 30,
  parameter int GS_BITS   = 9,
  parameter int CHANNELS  = 48,
  parameter int MUX_ROWS  = 8,
  parameter int CONF_BITS = 48,
  parameter int PREP_LEN  = 15
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clk_enable,
  input  logic [NB_LANES-1:0]  framebuffer_dat,
  input  logic [CONF_BITS-1:0] serialized_conf,
  input  logic                 new_configuration_ready,
  input  logic                 position_sync,
  output logic                 drv_sclk,
  output logic                 drv_gclk,
  output logic                 drv_lat,
  output logic [NB_LANES-1:0]  drv_sin,
  output logic                 column_ready,
  output logic                 driver_ready,
  output logic                 sync_overrun
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int wof(input int mx);
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

  localparam int WORD      = CHANNELS + 1;
  localparam int SEG       = (1 << GS_BITS) + 1;
  localparam int BLANK     = SEG - GS_BITS * WORD;
  localparam int WRTFC_LEN = 6;
`ifdef LINERESET_EN
  localparam int MIN_BLANK = 12;
`else
  localparam int MIN_BLANK = 8;
`endif

  // One shared step counter serves PREP/CONFIG/WRTFC lengths and the segment position.
  localparam int CNT_MAX = imax(imax(SEG - 1, CONF_BITS), imax(PREP_LEN - 1, WRTFC_LEN - 1));
  localparam int CNT_W   = wof(CNT_MAX);
  localparam int MUX_W   = wof(MUX_ROWS - 1);
  localparam int BIT_W   = wof(CHANNELS);
  localparam int WRD_W   = wof(GS_BITS - 1);
  localparam int CIDX_W  = wof(CONF_BITS - 1);

  if (BLANK < MIN_BLANK) begin : g_blank_check
    $error("tlc_driver_sequencer: blanking window shorter than the latch sequence needs");
  end

  typedef enum logic [2:0] {
    ST_STALL,
    ST_PREP_CONFIG,
    ST_CONFIG,
    ST_WRTFC_WAIT,
    ST_WAIT_SLICE,
    ST_STREAM
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [MUX_W-1:0]   mux_cnt, mux_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [WRD_W-1:0]   word_cnt, word_n;
  logic               tail, tail_n;
  logic [CIDX_W-1:0]  conf_idx;
  logic               sclk_on, gclk_on, lat_d, data_slot, col_rdy, overrun_d;
  logic [NB_LANES-1:0] sin_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= ST_STALL;
      cnt          <= '0;
      mux_cnt      <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      tail         <= 1'b0;
      drv_lat      <= 1'b0;
      drv_sin      <= '0;
      sync_overrun <= 1'b0;
    end else begin
      sync_overrun <= clk_enable & overrun_d;
      if (clk_enable) begin
        state    <= state_n;
        cnt      <= cnt_n;
        mux_cnt  <= mux_n;
        bit_cnt  <= bit_n;
        word_cnt <= word_n;
        tail     <= tail_n;
        // LAT/SIN change on the edge that ends the SCLK pulse, giving the driver hold margin.
        drv_lat  <= lat_d;
        drv_sin  <= sin_d;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mux_n     = mux_cnt;
    bit_n     = bit_cnt;
    word_n    = word_cnt;
    tail_n    = tail;
    sclk_on   = 1'b0;
    gclk_on   = 1'b0;
    lat_d     = 1'b0;
    sin_d     = '0;
    data_slot = 1'b0;
    col_rdy   = 1'b0;
    overrun_d = 1'b0;
    conf_idx  = CIDX_W'(CONF_BITS - int'(cnt));

    case (state)
      ST_STALL: begin
        if (new_configuration_ready) begin
          state_n = ST_PREP_CONFIG;
          cnt_n   = '0;
        end
      end

      // FCWRTEN: LAT held high across PREP_LEN SCLK edges.
      ST_PREP_CONFIG: begin
        sclk_on = 1'b1;
        lat_d   = 1'b1;
        if (cnt == CNT_W'(PREP_LEN - 1)) begin
          state_n = ST_CONFIG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // Step 0 is the pause; steps 1..CONF_BITS shift MSB first, WRTFC on the last 5.
      ST_CONFIG: begin
        if (cnt != '0) begin
          sclk_on = 1'b1;
          sin_d   = {NB_LANES{serialized_conf[conf_idx]}};
          lat_d   = (cnt > CNT_W'(CONF_BITS - 5));
        end
        if (cnt == CNT_W'(CONF_BITS)) begin
          state_n = ST_WRTFC_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_WRTFC_WAIT: begin
        if (cnt == CNT_W'(WRTFC_LEN - 1)) begin
          state_n = ST_WAIT_SLICE;
          cnt_n   = '0;
          tail_n  = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // tail: the segment started by the end of the slice is still being clocked out.
      ST_WAIT_SLICE: begin
        if (tail) begin
          gclk_on = (cnt != '0);
          if (cnt == CNT_W'(SEG - 1)) begin
            col_rdy = 1'b1;
            tail_n  = 1'b0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        if (new_configuration_ready) begin
          state_n = ST_PREP_CONFIG;
          cnt_n   = '0;
          mux_n   = '0;
          bit_n   = '0;
          word_n  = '0;
          tail_n  = 1'b0;
        end else if (position_sync) begin
          state_n = ST_STREAM;
          cnt_n   = '0;
          mux_n   = '0;
          bit_n   = '0;
          word_n  = '0;
          tail_n  = 1'b0;
        end
      end

      ST_STREAM: begin
        gclk_on = (cnt != '0);
        if (cnt >= CNT_W'(BLANK)) begin
          // bit_cnt 0 is the inter-word pause; 1..CHANNELS carry data.
          if (bit_cnt != '0) begin
            sclk_on   = 1'b1;
            data_slot = 1'b1;
            sin_d     = framebuffer_dat;
            if (word_cnt != WRD_W'(GS_BITS - 1)) begin
              lat_d = (bit_cnt == BIT_W'(CHANNELS));
            end
`ifdef LINERESET_EN
            else if (mux_cnt == MUX_W'(MUX_ROWS - 1)) begin
              lat_d = (bit_cnt > BIT_W'(CHANNELS - 7));
            end
`endif
            else begin
              lat_d = (bit_cnt > BIT_W'(CHANNELS - 3));
            end
          end
          if (bit_cnt == BIT_W'(CHANNELS)) begin
            bit_n  = '0;
            word_n = word_cnt + 1'b1;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end

        if (cnt == CNT_W'(SEG - 1)) begin
          col_rdy = 1'b1;
          cnt_n   = '0;
          bit_n   = '0;
          word_n  = '0;
          if (mux_cnt == MUX_W'(MUX_ROWS - 1)) begin
            mux_n   = '0;
            state_n = ST_WAIT_SLICE;
            tail_n  = 1'b1;
          end else begin
            mux_n = mux_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end

        // Reconfiguration takes priority over everything, including overrun reporting.
        if (new_configuration_ready) begin
          state_n = ST_PREP_CONFIG;
          cnt_n   = '0;
          mux_n   = '0;
          bit_n   = '0;
          word_n  = '0;
          tail_n  = 1'b0;
        end else if (position_sync) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_n = ST_STALL;
        cnt_n   = '0;
      end
    endcase
  end

  assign drv_sclk     = clk_enable & sclk_on;
  assign drv_gclk     = clk_enable & gclk_on;
  assign column_ready = clk_enable & col_rdy;
  // The framebuffer fetches during the gap cycles before the enable that shifts the bit.
  assign driver_ready = ~clk_enable & data_slot;

endmodule

// File: tb/tb_tlc_driver_sequencer.sv
// tb/tb_tlc_driver_sequencer.sv - self-checking bench for tlc_driver_sequencer
module tb_tlc_driver_sequencer;

  localparam int NB_LANES  = 30;
  localparam int GS_BITS   = 9;
  localparam int CHANNELS  = 48;
  localparam int MUX_ROWS  = 8;
  localparam int CONF_BITS = 48;
  localparam int PREP_LEN  = 15;

  localparam int WORD  = CHANNELS + 1;
  localparam int SEG   = (1 << GS_BITS) + 1;
  localparam int BLANK = SEG - GS_BITS * WORD;
  localparam int SLICE = MUX_ROWS * SEG;
`ifdef LINERESET_EN
  localparam bit LR = 1'b1;
`else
  localparam bit LR = 1'b0;
`endif

  localparam int PH_STALL = 0, PH_PREP = 1, PH_CONF = 2, PH_WFC = 3, PH_WAIT = 4, PH_STREAM = 5;

  logic clk = 1'b0;
  logic nrst;
  logic clk_enable;
  logic [NB_LANES-1:0]  framebuffer_dat;
  logic [CONF_BITS-1:0] conf_word;
  logic new_configuration_ready;
  logic position_sync;
  logic drv_sclk, drv_gclk, drv_lat, column_ready, driver_ready, sync_overrun;
  logic [NB_LANES-1:0] drv_sin;

  always #5 clk = ~clk;

  tlc_driver_sequencer #(
    .NB_LANES(NB_LANES), .GS_BITS(GS_BITS), .CHANNELS(CHANNELS),
    .MUX_ROWS(MUX_ROWS), .CONF_BITS(CONF_BITS), .PREP_LEN(PREP_LEN)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .clk_enable(clk_enable),
    .framebuffer_dat(framebuffer_dat),
    .serialized_conf(conf_word),
    .new_configuration_ready(new_configuration_ready),
    .position_sync(position_sync),
    .drv_sclk(drv_sclk),
    .drv_gclk(drv_gclk),
    .drv_lat(drv_lat),
    .drv_sin(drv_sin),
    .column_ready(column_ready),
    .driver_ready(driver_ready),
    .sync_overrun(sync_overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase plus slot index within the phase; stream slots index the whole slice.
  int m_ph, m_i;
  bit m_tail;
  logic hold_lat;
  logic [NB_LANES-1:0] hold_sin;

  int n_sclk, n_gclk, n_col, n_lat, n_slots, first_sclk, n_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd_en();
    return ($urandom_range(0, 2) != 0);
  endfunction

  function automatic void model_slot(output bit sclk, output bit gclk, output bit lat,
                                     output bit data, output bit col,
                                     output logic [NB_LANES-1:0] sin);
    int row, k, p, b, w, nlat;
    sclk = 0; gclk = 0; lat = 0; data = 0; col = 0; sin = '0;
    case (m_ph)
      PH_PREP: begin
        sclk = 1; lat = 1;
      end
      PH_CONF: begin
        if (m_i > 0) begin
          sclk = 1;
          lat  = (m_i > CONF_BITS - 5);
          sin  = {NB_LANES{conf_word[CONF_BITS - m_i]}};
        end
      end
      PH_WAIT: begin
        if (m_tail) begin
          gclk = (m_i != 0);
          col  = (m_i == SEG - 1);
        end
      end
      PH_STREAM: begin
        row  = m_i / SEG;
        k    = m_i % SEG;
        gclk = (k != 0);
        col  = (k == SEG - 1);
        if (k >= BLANK) begin
          p = k - BLANK;
          w = p / WORD;
          b = p % WORD;
          if (b != 0) begin
            sclk = 1; data = 1; sin = framebuffer_dat;
            nlat = (w < GS_BITS - 1) ? 1 : ((LR && row == MUX_ROWS - 1) ? 7 : 3);
            lat  = (b > CHANNELS - nlat);
          end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void model_advance(input logic sync, input logic cfg);
    case (m_ph)
      PH_STALL: if (cfg) begin m_ph = PH_PREP; m_i = 0; end
      PH_PREP: if (m_i == PREP_LEN - 1) begin m_ph = PH_CONF; m_i = 0; end else m_i++;
      PH_CONF: if (m_i == CONF_BITS) begin m_ph = PH_WFC; m_i = 0; end else m_i++;
      PH_WFC: if (m_i == 5) begin m_ph = PH_WAIT; m_i = 0; m_tail = 0; end else m_i++;
      PH_WAIT: begin
        if (m_tail) begin
          if (m_i == SEG - 1) begin m_tail = 0; m_i = 0; end else m_i++;
        end
        if (cfg) begin m_ph = PH_PREP; m_i = 0; m_tail = 0; end
        else if (sync) begin m_ph = PH_STREAM; m_i = 0; m_tail = 0; end
      end
      PH_STREAM: begin
        if (cfg) begin m_ph = PH_PREP; m_i = 0; end
        else if (m_i == SLICE - 1) begin m_ph = PH_WAIT; m_i = 0; m_tail = 1; end
        else m_i++;
      end
      default: ;
    endcase
  endfunction

  task automatic clear_counts();
    n_sclk = 0; n_gclk = 0; n_col = 0; n_lat = 0; n_slots = 0; first_sclk = -1;
  endtask

  // One clk cycle, entered and left at the falling edge.
  task automatic tick(input logic en, input logic sync, input logic cfg);
    bit e_sclk, e_gclk, e_lat, e_data, e_col, e_ovr;
    logic [NB_LANES-1:0] e_sin;
    clk_enable = en;
    position_sync = sync;
    new_configuration_ready = cfg;
    framebuffer_dat = NB_LANES'($urandom);
    #1;
    model_slot(e_sclk, e_gclk, e_lat, e_data, e_col, e_sin);
    chk("drv_sclk", drv_sclk, en & e_sclk);
    chk("drv_gclk", drv_gclk, en & e_gclk);
    chk("column_ready", column_ready, en & e_col);
    chk("driver_ready", driver_ready, !en & e_data);
    if (drv_sclk && first_sclk < 0) first_sclk = n_slots;
    n_sclk += int'(drv_sclk);
    n_gclk += int'(drv_gclk);
    n_col  += int'(column_ready);
    e_ovr = en && (m_ph == PH_STREAM) && sync && !cfg;
    if (en) begin
      hold_lat = e_lat;
      hold_sin = e_sin;
      model_advance(sync, cfg);
      n_slots++;
    end
    @(posedge clk);
    #1;
    chk("drv_lat", drv_lat, hold_lat);
    chk("drv_sin", drv_sin, hold_sin);
    chk("sync_overrun", sync_overrun, e_ovr);
    n_lat += int'(en && drv_lat);
    n_ovr += int'(sync_overrun);
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick(rnd_en(), 1'b0, 1'b0);
  endtask

  task automatic run_until_phase(input int ph, input int budget, input string tag);
    int n;
    n = 0;
    while (m_ph != ph && n < budget) begin
      tick(rnd_en(), 1'b0, 1'b0);
      n++;
    end
    chk({tag, " within budget"}, (n < budget), 1'b1);
  endtask

  task automatic run_until_tail_done(input int budget);
    int n;
    n = 0;
    while (m_tail && n < budget) begin
      tick(rnd_en(), 1'b0, 1'b0);
      n++;
    end
    chk("tail within budget", (n < budget), 1'b1);
  endtask

  task automatic run_to_slot(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (!(m_ph == PH_STREAM && m_i == target) && n < budget) begin
      tick(rnd_en(), 1'b0, 1'b0);
      n++;
    end
    chk({tag, " within budget"}, (n < budget), 1'b1);
  endtask

  initial begin
    nrst = 1'b0;
    clk_enable = 1'b0;
    position_sync = 1'b0;
    new_configuration_ready = 1'b0;
    framebuffer_dat = '0;
    conf_word = CONF_BITS'(48'hA5A5_0000_FFFF);
    m_ph = PH_STALL; m_i = 0; m_tail = 0;
    hold_lat = 1'b0; hold_sin = '0;
    n_ovr = 0;
    clear_counts();

    // Reset: outputs low even with the strobe and lanes active.
    repeat (4) @(posedge clk);
    #1;
    clk_enable = 1'b1;
    framebuffer_dat = '1;
    #1;
    chk("reset drv_sclk", drv_sclk, 1'b0);
    chk("reset drv_gclk", drv_gclk, 1'b0);
    chk("reset drv_lat", drv_lat, 1'b0);
    chk("reset drv_sin", drv_sin, '0);
    chk("reset column_ready", column_ready, 1'b0);
    chk("reset driver_ready", driver_ready, 1'b0);
    chk("reset sync_overrun", sync_overrun, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    clk_enable = 1'b0;

    // Boot configuration.
    run_ticks(10);
    tick(1'b1, 1'b0, 1'b1);
    clear_counts();
    run_until_phase(PH_WAIT, 1000, "boot");
    chk("boot sclk count", n_sclk, PREP_LEN + CONF_BITS);
    chk("boot lat count", n_lat, PREP_LEN + 5);
    chk("boot gclk count", n_gclk, 0);
    run_ticks(20);

    // Full slice, then GCLK tail with no further sync.
    tick(1'b1, 1'b1, 1'b0);
    clear_counts();
    run_until_phase(PH_WAIT, 20000, "slice");
    chk("slice blank lead", first_sclk, BLANK + 1);
    chk("slice sclk count", n_sclk, MUX_ROWS * GS_BITS * CHANNELS);
    chk("slice gclk count", n_gclk, MUX_ROWS * (SEG - 1));
    chk("slice column_ready count", n_col, MUX_ROWS);
    chk("slice lat count", n_lat, MUX_ROWS * (GS_BITS + 2) + (LR ? 4 : 0));
    clear_counts();
    run_until_tail_done(3000);
    chk("tail gclk count", n_gclk, SEG - 1);
    chk("tail column_ready count", n_col, 1);
    clear_counts();
    run_ticks(40);
    chk("stopped gclk count", n_gclk, 0);

    // Second slice: overrun mid-stream, then abort at mux 3 / seg 200.
    tick(1'b1, 1'b1, 1'b0);
    run_to_slot(2 * SEG + 77, 20000, "overrun point");
    tick(1'b1, 1'b1, 1'b0);
    run_to_slot(3 * SEG + 200, 20000, "abort point");
    tick(1'b1, 1'b0, 1'b1);
    clear_counts();
    tick(1'b1, 1'b0, 1'b0);
    chk("abort gclk after", n_gclk, 0);
    chk("abort prep sclk", n_sclk, 1);
    run_until_phase(PH_WAIT, 1000, "reconfig");
    chk("reconfig sclk count", n_sclk, PREP_LEN + CONF_BITS);
    chk("reconfig lat count", n_lat, PREP_LEN + 5);

    // Collision in WAIT_SLICE: configuration wins.
    run_ticks(5);
    tick(1'b1, 1'b1, 1'b1);
    run_until_phase(PH_WAIT, 1000, "collision wait");

    // Collision in STREAM: configuration wins, no overrun.
    tick(1'b1, 1'b1, 1'b0);
    run_ticks(150);
    tick(1'b1, 1'b1, 1'b1);
    run_until_phase(PH_WAIT, 1000, "collision stream");
    run_ticks(10);
    chk("total overrun pulses", n_ovr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
